// File: rtl/yarp_fetch.sv
// Instruction fetch stage: one outstanding imem request at a time, redirect kills
// an in-flight response, and a single registered instruction slot feeds decode.
module yarp_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        branch_taken_i,
    input  logic [31:0] next_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_VALID = 2'd3;

    logic [1:0]  state, state_next;
    logic [31:0] pc, pc_next;
    logic        kill, kill_next;
    logic        load_instr;
    logic        clear_valid;
    logic [31:0] redirect_pc;

    // Redirect targets are forced onto a word boundary.
    assign redirect_pc = next_pc_i & ~32'd3;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path infers a latch.
        state_next  = state;
        pc_next     = pc;
        kill_next   = kill;
        load_instr  = 1'b0;
        clear_valid = 1'b0;

        // A redirect wins over the response and over decode acceptance.
        if (branch_taken_i) begin
            pc_next = redirect_pc;
        end

        case (state)
            S_IDLE: begin
                state_next = S_REQ;
            end
            S_REQ: begin
                if (imem_gnt_i) begin
                    state_next = S_WAIT;
                    kill_next  = branch_taken_i;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    kill_next = 1'b0;
                    if (branch_taken_i || kill) begin
                        state_next = S_REQ;
                    end else begin
                        load_instr = 1'b1;
                        pc_next    = pc + 32'd4;
                        state_next = S_VALID;
                    end
                end else if (branch_taken_i) begin
                    kill_next = 1'b1;
                end
            end
            S_VALID: begin
                if (branch_taken_i || instr_ready_i) begin
                    clear_valid = 1'b1;
                    state_next  = S_REQ;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            pc            <= RESET_PC;
            kill          <= 1'b0;
            instr_valid_o <= 1'b0;
            instr_o       <= 32'd0;
            instr_pc_o    <= 32'd0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            kill  <= kill_next;
            if (load_instr) begin
                instr_valid_o <= 1'b1;
                instr_o       <= imem_rdata_i;
                instr_pc_o    <= pc;
            end else if (clear_valid) begin
                instr_valid_o <= 1'b0;
            end
        end
    end

    assign imem_req_o  = (state == S_REQ);
    assign imem_addr_o = pc;

endmodule

// File: tb/tb_yarp_fetch.sv
// Directed bench for yarp_fetch: drives imem and decode handshakes cycle by cycle
// and compares outputs against hand-computed values.
module tb_yarp_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        branch_taken_i;
    logic [31:0] next_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    int n_checks = 0;
    int n_pass   = 0;

    yarp_fetch #(.RESET_PC(32'h0000_1000)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .branch_taken_i(branch_taken_i),
        .next_pc_i     (next_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed === expected) n_pass++;
        else $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    endtask

    // Advance one clock; inputs and samples both sit 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starting in REQ: check the request, grant at once, respond one cycle later,
    // and check the registered instruction one cycle after the response.
    task automatic fetch_one(input string tag, input logic [31:0] addr, input logic [31:0] data);
        check({tag, "_req"}, {31'd0, imem_req_o}, 32'd1);
        check({tag, "_addr"}, imem_addr_o, addr);
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        check({tag, "_wait_req"}, {31'd0, imem_req_o}, 32'd0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = data;
        step();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'd0;
        check({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd1);
        check({tag, "_instr"}, instr_o, data);
        check({tag, "_pc"}, instr_pc_o, addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n        = 1'b0;
        branch_taken_i = 1'b0;
        next_pc_i      = 32'd0;
        imem_gnt_i     = 1'b0;
        imem_rvalid_i  = 1'b0;
        imem_rdata_i   = 32'd0;
        instr_ready_i  = 1'b1;

        // Reset state
        step();
        step();
        check("rst_req",   {31'd0, imem_req_o},    32'd0);
        check("rst_addr",  imem_addr_o,            32'h0000_1000);
        check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        check("rst_instr", instr_o,                32'd0);
        check("rst_ipc",   instr_pc_o,             32'd0);

        // Release: one cycle in IDLE, then REQ
        reset_n = 1'b1;
        step();

        // Basic fetch with ready held high
        fetch_one("f0", 32'h0000_1000, 32'h1111_0013);
        step();
        check("f0_consumed", {31'd0, instr_valid_o}, 32'd0);
        fetch_one("f1", 32'h0000_1004, 32'h2222_0093);
        step();
        fetch_one("f2", 32'h0000_1008, 32'h3333_0113);
        step();

        // Backpressure: five cycles of ready=0 in VALID
        instr_ready_i = 1'b0;
        fetch_one("bp", 32'h0000_100C, 32'h4444_0193);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_valid", {31'd0, instr_valid_o}, 32'd1);
            check("bp_hold_instr", instr_o,                32'h4444_0193);
            check("bp_hold_pc",    instr_pc_o,             32'h0000_100C);
            check("bp_hold_noreq", {31'd0, imem_req_o},    32'd0);
        end
        instr_ready_i = 1'b1;
        step();
        check("bp_next_req",  {31'd0, imem_req_o}, 32'd1);
        check("bp_next_addr", imem_addr_o,         32'h0000_1010);

        // Kill in flight: redirect during WAIT, late response must be dropped
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i     = 1'b0;
        branch_taken_i = 1'b1;
        next_pc_i      = 32'h0000_2002;
        step();
        branch_taken_i = 1'b0;
        imem_rvalid_i  = 1'b1;
        imem_rdata_i   = 32'hDEAD_BEEF;
        step();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'd0;
        check("kill_valid", {31'd0, instr_valid_o}, 32'd0);
        check("kill_instr", instr_o,                32'h4444_0193);
        fetch_one("kill_tgt", 32'h0000_2000, 32'h5555_0213);
        step();

        // Grant held off four cycles, then redirect while still ungranted
        for (int i = 0; i < 4; i++) begin
            step();
            check("nogrant_req",  {31'd0, imem_req_o}, 32'd1);
            check("nogrant_addr", imem_addr_o,         32'h0000_2004);
        end
        branch_taken_i = 1'b1;
        next_pc_i      = 32'h0000_3000;
        step();
        branch_taken_i = 1'b0;
        check("redir_req_addr", imem_addr_o, 32'h0000_3000);
        fetch_one("redir_tgt", 32'h0000_3000, 32'h6666_0293);
        step();

        // Wrap-around from the top word of the address space
        branch_taken_i = 1'b1;
        next_pc_i      = 32'hFFFF_FFFC;
        step();
        branch_taken_i = 1'b0;
        fetch_one("wrap", 32'hFFFF_FFFC, 32'h7777_0313);
        step();
        check("wrap_addr", imem_addr_o, 32'h0000_0000);

        // Redirect in VALID together with acceptance still clears valid
        fetch_one("vredir", 32'h0000_0000, 32'h8888_0393);
        branch_taken_i = 1'b1;
        next_pc_i      = 32'h0000_4003;
        step();
        branch_taken_i = 1'b0;
        check("vredir_valid", {31'd0, instr_valid_o}, 32'd0);
        check("vredir_req",   {31'd0, imem_req_o},    32'd1);
        check("vredir_addr",  imem_addr_o,            32'h0000_4000);

        // Reset during WAIT, then a stray response after release
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        reset_n    = 1'b0;
        step();
        reset_n       = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hBAD0_BAD0;
        step();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'd0;
        check("mrst_valid", {31'd0, instr_valid_o}, 32'd0);
        check("mrst_req",   {31'd0, imem_req_o},    32'd1);
        check("mrst_addr",  imem_addr_o,            32'h0000_1000);
        step();
        check("mrst_valid2", {31'd0, instr_valid_o}, 32'd0);
        check("mrst_instr",  instr_o,                32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/yarp_fetch.md
YARP_FETCH -- requirements
Module: yarp_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_1000, is the first fetch address after reset; it SHALL be word-aligned.
REQ-002 The port clk SHALL be an input, 1 bit wide; it is the single clock, and all state SHALL update on its rising edge.
REQ-003 The port reset_n SHALL be an input, 1 bit wide; it is the reset, which is synchronous and active-low.
REQ-004 The port branch_taken_i SHALL be an input, 1 bit wide; it is the redirect request from branch resolution.
REQ-005 The port next_pc_i SHALL be an input, 32 bits wide; it is the redirect target and is sampled only when branch_taken_i=1.
REQ-006 The port imem_req_o SHALL be an output, 1 bit wide; it is the instruction memory request valid.
REQ-007 The port imem_addr_o SHALL be an output, 32 bits wide; it is the request address.
REQ-008 The port imem_gnt_i SHALL be an input, 1 bit wide; the memory accepts the request in any cycle where imem_req_o=1 and imem_gnt_i=1.
REQ-009 The port imem_rvalid_i SHALL be an input, 1 bit wide; it marks a read response valid.
REQ-010 The port imem_rdata_i SHALL be an input, 32 bits wide; it is the read response data.
REQ-011 The port instr_valid_o SHALL be an output, 1 bit wide; it marks a fetched instruction as valid toward decode.
REQ-012 The port instr_o SHALL be an output, 32 bits wide; it is the fetched instruction word.
REQ-013 The port instr_pc_o SHALL be an output, 32 bits wide; it is the address of instr_o.
REQ-014 The port instr_ready_i SHALL be an input, 1 bit wide; it is the decode accept, and the instruction is consumed in any cycle where instr_valid_o=1 and instr_ready_i=1.

Function
REQ-015 The block SHALL keep a state machine with states IDLE, REQ, WAIT and VALID, and SHALL allow at most one memory request outstanding.
REQ-016 IDLE SHALL move to REQ unconditionally after one cycle.
REQ-017 In REQ, imem_req_o SHALL be 1 and imem_addr_o SHALL equal pc; a grant SHALL move the machine to WAIT.
REQ-018 Without a redirect, imem_addr_o SHALL hold stable while imem_req_o=1 and imem_gnt_i=0.
REQ-019 In WAIT, a response arriving with imem_rvalid_i=1 and no kill pending SHALL do all of the following in one edge: register instr_o=imem_rdata_i, instr_pc_o=pc and instr_valid_o=1; set pc to pc+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0); and move to VALID.
REQ-020 The latency from response to output SHALL be exactly 1 cycle.
REQ-021 In VALID, instr_valid_o SHALL stay 1 and instr_o/instr_pc_o SHALL stay stable until accepted; acceptance SHALL clear instr_valid_o and move to REQ, so the next request is asserted in the following cycle.
REQ-022 imem_req_o SHALL be 0 in IDLE, WAIT and VALID.
REQ-023 A redirect (branch_taken_i=1) SHALL load pc with {next_pc_i[31:2],2'b00}, so bits [1:0] of the target are ignored.
REQ-024 A redirect in REQ without a grant SHALL leave the machine in REQ, and imem_addr_o SHALL show the target in the next cycle.
REQ-025 A redirect in REQ with a grant in the same cycle SHALL move the machine to WAIT with kill set.
REQ-026 A redirect in WAIT SHALL set kill; if the response arrives in the same cycle, the response SHALL be dropped and the machine SHALL move to REQ.
REQ-027 In WAIT with kill set, the response SHALL be dropped (no output update, pc unchanged), kill SHALL clear, and the machine SHALL move to REQ.
REQ-028 A redirect in VALID SHALL clear instr_valid_o in the next cycle even when the instruction is accepted in the same cycle, and SHALL move the machine to REQ.
REQ-029 A redirect in IDLE SHALL update pc, and the machine SHALL still move to REQ.
REQ-030 imem_rvalid_i SHALL be ignored outside WAIT.
REQ-031 A redirect takes priority over both the response and the decode acceptance.
REQ-032 A redirected-to instruction SHALL reach instr_valid_o no earlier than 3 cycles after the redirect cycle when imem grants immediately and responds 1 cycle after the grant.

Reset
REQ-033 While reset_n=0 at a clock edge, the block SHALL set state to IDLE, pc to RESET_PC, kill to 0, imem_req_o to 0, imem_addr_o to RESET_PC, instr_valid_o to 0, instr_o to 0 and instr_pc_o to 0.
REQ-034 Reset asserted mid-transaction SHALL abandon the outstanding request, and a late imem_rvalid_i after reset SHALL be ignored.

Verification
REQ-035 The bench SHALL cover basic fetch: release reset with immediate gnt, rvalid 1 cycle after the grant, and ready held at 1 -> imem_addr_o carries 0x1000, 0x1004 and 0x1008 in order, and instr_pc_o matches the address of each instr_o.
REQ-036 The bench SHALL cover backpressure: ready=0 for 5 cycles while instr_valid_o=1 -> instr_o/instr_pc_o stay stable, imem_req_o stays 0, and one cycle after ready=1 a request goes out to pc+4.
REQ-037 The bench SHALL cover a kill in flight: redirect to 0x2002 during WAIT, then rvalid with data 0xDEADBEEF -> that data never appears on instr_o, the next imem_addr_o is 0x2000, and the next instr_pc_o is 0x2000.
REQ-038 The bench SHALL cover a grant held off for 4 cycles: gnt=0 for 4 cycles -> imem_addr_o stays stable; then a redirect to 0x3000 while still ungranted -> imem_addr_o is 0x3000 in the next cycle.
REQ-039 The bench SHALL cover wrap-around: redirect to 0xFFFF_FFFC and complete the fetch -> the next request address is 0x0000_0000.
REQ-040 The bench SHALL cover mid-operation reset: reset_n=0 during WAIT, then a stray rvalid after release -> instr_valid_o stays 0, and the first request after release is to 0x1000.
